// File: rtl/load_store_unit_if.sv
// Bundles for the load/store unit.
//   lsu_req_if        : pipeline <-> LSU request/response channel.
//                       master = pipeline (issues requests), slave = LSU.
//   load_store_unit_if: LSU <-> data-memory bus (word addressed, byte enables).
//                       master = LSU (initiator), slave = memory.

interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_func3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_store, req_func3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_store, req_func3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

interface load_store_unit_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store initiator. Accepts one LB/LH/LW/LBU/LHU/SB/SH/SW at a time,
// issues one or two word-aligned byte-enabled beats on the memory bus (two when
// the access crosses a word boundary), assembles and extends load data, and
// returns a single one-cycle response.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : lsu_req_if.slave - request in, response out (rsp_valid pulse)
//   mem        : load_store_unit_if.master - data-memory bus, one beat outstanding
// Every output comes straight from a flop.

module load_store_unit (
  input  logic              clk,
  input  logic              rst_n,
  lsu_req_if.slave          req,
  load_store_unit_if.master mem
);

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_e;

  // Legal encodings: stores 0..2, loads 0,1,2,4,5.
  function automatic logic legal_f(input logic st, input logic [2:0] f3);
    if (st) return (f3 <= 3'd2);
    return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
  endfunction

  // Byte lanes over two consecutive words: [3:0] beat 0, [7:4] beat 1.
  function automatic logic [7:0] lanes_f(input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] base;
    case (f3[1:0])
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic [DW-1:0] byte_mask_f(input logic [3:0] be);
    logic [DW-1:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
    return m;
  endfunction

  // Store data trimmed to the access size and shifted across two words.
  function automatic logic [2*DW-1:0] wlanes_f(input logic [2:0] f3, input logic [1:0] off,
                                               input logic [DW-1:0] wdata);
    logic [7:0]    l;
    logic [DW-1:0] m;
    l = lanes_f(f3, 2'd0);
    m = byte_mask_f(l[3:0]);
    return {32'd0, wdata & m} << {off, 3'b000};
  endfunction

  function automatic logic [DW-1:0] extend_f(input logic [2:0] f3, input logic [DW-1:0] raw);
    case (f3)
      3'd0:    return {{24{raw[7]}}, raw[7:0]};
      3'd1:    return {{16{raw[15]}}, raw[15:0]};
      3'd4:    return {24'd0, raw[7:0]};
      3'd5:    return {16'd0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  state_e        state_q, state_d;
  logic          store_q, store_d;
  logic [2:0]    func3_q, func3_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rbuf_q, rbuf_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;

  // Beat geometry comes from the live request in IDLE, from the latched one after.
  logic          is_idle_c;
  logic [2:0]    src_func3_c;
  logic [DW-1:0] src_addr_c;
  logic [DW-1:0] src_wdata_c;
  logic [7:0]    lanes_c;
  logic [2*DW-1:0] wlanes_c;
  logic          split_c;
  logic [4:0]    shamt_c;
  logic [DW-1:0] beat0_c;
  logic [DW-1:0] beat1_c;
  logic [2*DW-1:0] asm0_c;
  logic [2*DW-1:0] asm1_c;
  logic [DW-1:0] base_addr_c;

  assign is_idle_c   = (state_q == IDLE);
  assign src_func3_c = is_idle_c ? req.req_func3 : func3_q;
  assign src_addr_c  = is_idle_c ? req.req_addr  : addr_q;
  assign src_wdata_c = is_idle_c ? req.req_wdata : wdata_q;
  assign lanes_c     = lanes_f(src_func3_c, src_addr_c[1:0]);
  assign wlanes_c    = wlanes_f(src_func3_c, src_addr_c[1:0], src_wdata_c);
  assign split_c     = |lanes_c[7:4];
  assign shamt_c     = {src_addr_c[1:0], 3'b000};
  assign base_addr_c = {src_addr_c[DW-1:2], 2'b00};

  // Keep only the bytes this access owns, then realign to the LSB.
  assign beat0_c = mem.mem_rdata & byte_mask_f(lanes_c[3:0]);
  assign beat1_c = mem.mem_rdata & byte_mask_f(lanes_c[7:4]);
  assign asm0_c  = {32'd0, beat0_c} >> shamt_c;
  assign asm1_c  = {beat1_c, rbuf_q} >> shamt_c;

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      store_q     <= 1'b0;
      func3_q     <= 3'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'd0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      store_q     <= store_d;
      func3_q     <= func3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    store_d     = store_q;
    func3_d     = func3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (req.req_valid) begin
          store_d = req.req_store;
          func3_d = req.req_func3;
          addr_d  = req.req_addr;
          wdata_d = req.req_wdata;
          rbuf_d  = '0;
          if (!legal_f(req.req_store, req.req_func3)) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            state_d     = REQ0;
            mem_we_d    = req.req_store;
            mem_addr_d  = base_addr_c;
            mem_be_d    = lanes_c[3:0];
            mem_wdata_d = wlanes_c[DW-1:0];
          end
        end
      end
      REQ0, REQ1: begin
        if (mem.mem_gnt) begin
          state_d     = (state_q == REQ0) ? WAIT0 : WAIT1;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_be_d    = 4'd0;
          mem_wdata_d = '0;
        end
      end
      WAIT0: begin
        if (mem.mem_rvalid) begin
          rbuf_d = store_q ? '0 : beat0_c;
          if (split_c) begin
            state_d     = REQ1;
            mem_we_d    = store_q;
            mem_addr_d  = base_addr_c + 32'd4;
            mem_be_d    = lanes_c[7:4];
            mem_wdata_d = wlanes_c[2*DW-1:DW];
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = store_q ? '0 : extend_f(func3_q, asm0_c[DW-1:0]);
          end
        end
      end
      WAIT1: begin
        if (mem.mem_rvalid) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = store_q ? '0 : extend_f(func3_q, asm1_c[DW-1:0]);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
    mem_req_d   = (state_d == REQ0) || (state_d == REQ1);
  end

  assign req.req_ready = req_ready_q;
  assign req.rsp_valid = rsp_valid_q;
  assign req.rsp_err   = rsp_err_q;
  assign req.rsp_rdata = rsp_rdata_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_be    = mem_be_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Core-side load/store initiator that turns one RV32I load or store (LB/LH/LW/LBU/LHU/SB/SH/SW) into word-addressed, byte-enabled transactions on the data-memory bus. It performs the lane shifting and byte-enable generation, and splits misaligned accesses into two word transactions. It also merges and sign- or zero-extends load data before returning a single response to the pipeline. It sits between the execute/memory stage and the dual-port data RAM.

## Interface
- No parameters; data and address are fixed at 32 bits.
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  pipeline presents a request
- req_ready  out  1  high only in IDLE; transfer occurs when req_valid && req_ready
- req_store  in  1  1 = store, 0 = load
- req_func3  in  3  0 byte, 1 half, 2 word, 4 ubyte, 5 uhalf (4/5 are loads only)
- req_addr  in  32  byte address, any alignment
- req_wdata  in  32  store data, LSB-justified
- rsp_valid  out  1  one-cycle pulse, no backpressure
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  illegal func3, valid with rsp_valid
- mem_req  out  1  bus request, held until mem_gnt
- mem_we  out  1  write beat
- mem_addr  out  32  word address, bits [1:0] always 0
- mem_be  out  4  byte-lane enables
- mem_wdata  out  32  lane-aligned write data
- mem_gnt  in  1  bus accepts the beat this cycle
- mem_rvalid  in  1  completion of the granted beat (read data or write ack), 1+ cycles after gnt
- mem_rdata  in  32  read data, valid with mem_rvalid

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: on a transfer, latch store, func3, addr, and wdata.
  - Illegal func3 goes to RESP with err.
  - Otherwise go to REQ0.
- Illegal func3: loads 3, 6, 7; stores any value above 2.
- Size n = 1, 2, or 4 bytes; off = addr[1:0]; split = (off+n > 4).
- Beat 0:
  - mem_addr = {addr[31:2], 2'b00}.
  - mem_be = lanes off to min(off+n, 4)-1.
  - mem_wdata = wdata << 8*off.
- Beat 1 (split only):
  - mem_addr = beat-0 address + 4, modulo 2^32.
  - mem_be = lanes 0 to off+n-5.
  - mem_wdata = wdata >> 8*(4-off).
- REQ0: mem_req = 1. On mem_gnt go to WAIT0.
- WAIT0: on mem_rvalid, a load captures the mem_rdata bytes under mem_be. Then go to REQ1 if split, else RESP.
- REQ1 and WAIT1: the same behaviour using beat 1; then go to RESP.
- Load assembly: result byte k = beat-0 lane off+k for k < 4-off, else beat-1 lane k-(4-off). Then sign-extend (func3 0/1) or zero-extend (func3 4/5) from 8n bits.
- RESP: drive the response outputs, pulse rsp_valid, then return to IDLE.
- mem_rvalid outside WAIT0/WAIT1 is ignored. mem_gnt outside REQ0/REQ1 is ignored.
- Only one beat is ever outstanding; no new request is accepted until RESP completes.

## Timing
- Reset values: req_ready 1, rsp_valid 0, rsp_rdata 0, rsp_err 0, mem_req 0, mem_we 0, mem_addr 0, mem_be 0, mem_wdata 0. State is IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from req_* or mem_* inputs to any output.
- mem_addr, mem_be, mem_we, and mem_wdata are stable from mem_req rising until mem_gnt. They are 0 whenever mem_req is 0.
- Aligned access, with gnt in the first REQ cycle and rvalid the next cycle:
  - accept at cycle T;
  - mem_req at T+1;
  - rvalid at T+2;
  - rsp_valid at T+3.
- A split access adds 2 cycles: rsp_valid at T+5.
- Illegal func3: rsp_valid with rsp_err at T+1; no mem_req.
- Each gnt stall cycle or rvalid delay cycle adds one cycle of latency.
- Asserting rst_n low mid-transaction:
  - immediately drops mem_req and any pending response;
  - abandons the outstanding beat; the bus is reset by the same rst_n.
- Address 0xFFFFFFFE with a word access: beat 1 goes to 0x00000000.

## Test plan
- Memory byte i = 0x14+i. LW at addr 0x0 -> one beat, be 4'b1111, rsp_rdata 0x17161514 at T+3.
- SB wdata 0xABCDEF80 at addr 0x5 -> mem_addr 0x4, be 4'b0010, wdata 0x00008000. A following LB at 0x5 returns 0xFFFFFF80; LBU at 0x5 returns 0x00000080.
- SW 0xDEADBEEF at addr 0x3 -> beat 0: addr 0x0, be 4'b1000, wdata 0xEF000000; beat 1: addr 0x4, be 4'b0111, wdata 0x00DEADBE. LW at 0x3 returns 0xDEADBEEF at T+5.
- LH at 0x7 where byte 7 = 0x34 and byte 8 = 0x92 -> split into beats at addr 0x4 and 0x8; rsp_rdata 0xFFFF9234. LHU at 0x7 returns 0x00009234.
- Stalls and errors:
  - mem_gnt held low 3 cycles and rvalid 2 cycles after gnt -> mem_req and payload stay stable; rsp_valid at T+7.
  - Store with func3 4 -> rsp_err 1 at T+1; mem_req never asserts.
- rst_n pulsed low while in WAIT0 -> all outputs reach reset values asynchronously; no rsp_valid. A new LW after release completes normally.
